// File: rtl/seq_mac_pkg.sv
// Shared definitions for the sequential multiply-accumulate engine.
// Contents: FSM state enum, state-register width, counter-width helper.
package seq_mac_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Bit-serial shift-add multiplier: one multiplier bit per step.
// Ports:
//   clk, reset   clock, async active-low reset
//   load         load a_in/b_in, clear product and bit counter
//   step         consume one multiplier bit
//   a_in, b_in   unsigned operands (WIDTH)
//   product      running product (2*WIDTH), final after WIDTH steps
//   last_c       combinational: the current step is the final one
module shift_add_mult
  import seq_mac_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned BW = cnt_w(WIDTH);

  logic [PW-1:0]    a_shift_q, a_shift_d;
  logic [WIDTH-1:0] b_shift_q, b_shift_d;
  logic [PW-1:0]    product_q, product_d;
  logic [BW-1:0]    bit_q, bit_d;

  // Next-state for the shift registers, product and bit counter.
  always_comb begin
    a_shift_d = a_shift_q;
    b_shift_d = b_shift_q;
    product_d = product_q;
    bit_d     = bit_q;
    if (load) begin
      a_shift_d = PW'(a_in);
      b_shift_d = b_in;
      product_d = '0;
      bit_d     = '0;
    end else if (step) begin
      if (b_shift_q[0]) begin
        product_d = product_q + a_shift_q;
      end
      a_shift_d = a_shift_q << 1;
      b_shift_d = b_shift_q >> 1;
      bit_d     = bit_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_shift_q <= '0;
      b_shift_q <= '0;
      product_q <= '0;
      bit_q     <= '0;
    end else begin
      a_shift_q <= a_shift_d;
      b_shift_q <= b_shift_d;
      product_q <= product_d;
      bit_q     <= bit_d;
    end
  end

  assign last_c  = (bit_q == BW'(WIDTH - 1));
  assign product = product_q;

endmodule

// File: rtl/seq_mac_unit.sv
// Sequential multiply-accumulate: sum of CHANNELS unsigned products computed
// on one shared bit-serial multiplier, optionally accumulated onto the
// previous result, with sticky overflow.
// Build option: define SEQ_MAC_SATURATE_EN to clamp the accumulator to all
// ones on carry-out instead of wrapping.
// Ports:
//   clk, reset        clock, async active-low reset
//   start, acc_keep   request (IDLE only); keep = add onto current result
//   a_flat, b_flat    packed operands, channel k at [k*WIDTH +: WIDTH]
//   busy              operation in progress (MULT/ACCUM/DONE)
//   done              one-cycle completion pulse
//   result            last completed sum (ACC_WIDTH)
//   overflow          sticky carry-out flag, cleared by start with keep=0
module seq_mac_unit
  import seq_mac_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned ACC_WIDTH = 17
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         acc_keep,
  input  logic [CHANNELS*WIDTH-1:0]    a_flat,
  input  logic [CHANNELS*WIDTH-1:0]    b_flat,
  output logic                         busy,
  output logic                         done,
  output logic [ACC_WIDTH-1:0]         result,
  output logic                         overflow
);

  localparam int unsigned OPW   = CHANNELS * WIDTH;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CW    = cnt_w(CHANNELS);
  localparam int unsigned SUM_W = ACC_WIDTH + 1;

  state_e               state_q, state_d;
  logic [OPW-1:0]       a_snap_q, a_snap_d;
  logic [OPW-1:0]       b_snap_q, b_snap_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 overflow_q, overflow_d;

  logic                 mult_load_c;
  logic                 mult_step_c;
  logic [WIDTH-1:0]     mult_a_c;
  logic [WIDTH-1:0]     mult_b_c;
  logic [PW-1:0]        product;
  logic                 last_c;
  logic [CW-1:0]        ch_nxt_c;
  logic [SUM_W-1:0]     sum_c;
  logic [ACC_WIDTH-1:0] acc_new_c;

  shift_add_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .load    (mult_load_c),
    .step    (mult_step_c),
    .a_in    (mult_a_c),
    .b_in    (mult_b_c),
    .product (product),
    .last_c  (last_c)
  );

  // Accumulator adder; carry-out is the extra top bit.
  always_comb begin
    sum_c     = SUM_W'(acc_q) + SUM_W'(product);
    acc_new_c = sum_c[ACC_WIDTH-1:0];
`ifdef SEQ_MAC_SATURATE_EN
    // Once clamped, any further nonzero product carries again, so it stays clamped.
    if (sum_c[ACC_WIDTH]) begin
      acc_new_c = '1;
    end
`endif
  end

  // FSM next-state, datapath control and registered-output next values.
  always_comb begin
    state_d     = state_q;
    a_snap_d    = a_snap_q;
    b_snap_d    = b_snap_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    mult_load_c = 1'b0;
    mult_step_c = 1'b0;
    ch_nxt_c    = ch_q + CW'(1);
    // Channel 0 loads straight from the ports in the accepting cycle.
    mult_a_c    = a_flat[WIDTH-1:0];
    mult_b_c    = b_flat[WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          a_snap_d    = a_flat;
          b_snap_d    = b_flat;
          acc_d       = acc_keep ? result_q : '0;
          if (!acc_keep) begin
            overflow_d = 1'b0;
          end
          ch_d        = '0;
          mult_load_c = 1'b1;
          state_d     = MULT;
        end
      end
      MULT: begin
        mult_step_c = 1'b1;
        if (last_c) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_new_c;
        if (sum_c[ACC_WIDTH]) begin
          overflow_d = 1'b1;
        end
        if (ch_q == CW'(CHANNELS - 1)) begin
          result_d = acc_new_c;
          state_d  = DONE;
        end else begin
          ch_d        = ch_nxt_c;
          mult_load_c = 1'b1;
          mult_a_c    = a_snap_q[int'(ch_nxt_c)*WIDTH +: WIDTH];
          mult_b_c    = b_snap_q[int'(ch_nxt_c)*WIDTH +: WIDTH];
          state_d     = MULT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_snap_q   <= '0;
      b_snap_q   <= '0;
      ch_q       <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_snap_q   <= a_snap_d;
      b_snap_q   <= b_snap_d;
      ch_q       <= ch_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule
